mod_addsub_pipe: RTL
====================

MOD_ADDSUB_PIPE -- requirements
Module: mod_addsub_pipe

Interface
REQ-001 The block SHALL have parameter W, default 16, operand/result width in bits.
REQ-002 The block SHALL have parameter Q, default 3329, modulus; legal range 2 <= Q < 2^W.
REQ-003 The block SHALL have parameter TAG_W, default 8, sideband tag width.
REQ-004 The port list SHALL be as follows:
- clk  in  1  sole clock; all state rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts beat this cycle.
- in_op  in  1  0 = (a+b) mod Q, 1 = (a-b) mod Q.
- in_a  in  W  operand A, expected in [0,Q).
- in_b  in  W  operand B, expected in [0,Q).
- in_tag  in  TAG_W  opaque tag, returned unchanged.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- out_res  out  W  result in [0,Q).
- out_tag  out  TAG_W  tag of this result.
- out_err  out  1  range-check flag (present only with MOD_ADDSUB_RANGE_CHK_EN).

Function
REQ-005 A transfer SHALL occur on an interface only when valid and ready are both high at a rising clk edge.
REQ-006 Stage 1 SHALL register op, tag and the raw W+1-bit value: a+b for add, a-b in two's complement for sub.
REQ-007 Stage 2 SHALL register the corrected result:
- add: raw-Q if raw >= Q, else raw.
- sub: raw+Q if raw is negative (bit W set), else raw.
- Final value truncated to W bits.
REQ-008 Latency SHALL be exactly 2 cycles from input acceptance to out_valid with no backpressure; throughput SHALL be 1 beat/cycle.
REQ-009 Stage 2 SHALL hold its data stable while out_valid=1 and out_ready=0.
REQ-010 Stage 1 SHALL advance when stage 2 is empty or draining; in_ready SHALL be high when stage 1 is empty or advancing (combinational from out_ready, no bubble).
REQ-011 Results SHALL leave in acceptance order, with each out_tag paired to its own operands.
REQ-012 Inputs outside [0,Q) SHALL produce an unspecified out_res but SHALL NOT corrupt other beats or the handshake.
REQ-013 When in_valid=0 or in_ready=0, the block SHALL load no new state into stage 1.

Reset
REQ-014 On rst_n low, the block SHALL asynchronously clear both stage valid bits, so out_valid=0, out_res=0, out_tag=0 and out_err=0.
REQ-015 After rst_n deasserts, in_ready SHALL be 1 in the first cycle.
REQ-016 Reset mid-operation SHALL discard all in-flight beats; none SHALL emerge after reset.

Configuration
REQ-017 The block SHALL support macro MOD_ADDSUB_RANGE_CHK_EN.
- Defined: out_err is present; stage 1 records (in_a >= Q) | (in_b >= Q); out_err travels with its beat.
- Undefined: out_err port and its logic are absent; all other behaviour is identical.

Structure
REQ-018 Package modarith_pkg SHALL hold:
- op encoding constants OP_ADD=0 and OP_SUB=1;
- KYBER_Q=3329 and DILITHIUM_Q=8380417;
- a stage-1 payload struct typedef.
REQ-019 The correction logic SHALL live in one combinational sub-module, mod_addsub_corr (raw, op -> corrected result); the two pipeline registers and handshake SHALL remain in mod_addsub_pipe.

Verification
REQ-020 The bench SHALL cover the following directed scenarios with W=16, Q=3329 unless stated:
- add a=3328, b=1, tag=0x11, out_ready=1 -> after 2 cycles out_res=0, out_tag=0x11; add 1000+2000 -> 3000.
- sub a=0, b=1 -> 3328; sub 5-5 -> 0; sub 3328-0 -> 3328.
- 8 back-to-back beats, out_ready=1 -> 8 consecutive out_valid cycles, in order, tags preserved.
- out_ready=0 for 5 cycles with a continuous input stream -> in_ready falls after 2 beats are held, out_res is stable, no beat is lost or duplicated on release.
- rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately, neither beat appears afterwards, in_ready=1 in the next cycle.
- MOD_ADDSUB_RANGE_CHK_EN defined, a=3329, b=0 -> out_err=1 for that beat only; rerun with W=23, Q=8380417: sub 0-1 -> 8380416.

Source files
------------

// File: rtl/modarith_pkg.sv
// Shared definitions for the modular add/sub pipeline: op encoding,
// common moduli and the stage-1 control payload.
// Optional feature macro: MOD_ADDSUB_RANGE_CHK_EN (adds the err field).
package modarith_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int unsigned KYBER_Q     = 3329;
    localparam int unsigned DILITHIUM_Q = 8380417;

    localparam int STAGES = 2;

    // Stage-1 control payload; raw value and tag are width-parameterized
    // and therefore kept as separate registers in the pipeline.
    typedef struct packed {
        logic op;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
        logic err;
`endif
    } s1_ctl_t;

endpackage

// File: rtl/mod_addsub_corr.sv
// Combinational modular correction: folds the W+1-bit raw sum/difference
// back into [0,Q). The comparison looks at the full raw value, but the
// arithmetic itself only needs W bits because the result is truncated.
module mod_addsub_corr
    import modarith_pkg::*;
#(
    parameter int          W = 16,
    parameter int unsigned Q = KYBER_Q
) (
    input  logic [W:0]   raw,
    input  logic         op,
    output logic [W-1:0] res
);

    localparam logic [W:0]   Q_EXT = (W+1)'(Q);
    localparam logic [W-1:0] Q_W   = W'(Q);

    // add: subtract Q once on overflow past Q; sub: add Q back when negative
    always_comb begin
        res = raw[W-1:0];
        if (op == OP_SUB) begin
            if (raw[W])
                res = raw[W-1:0] + Q_W;
        end else if (raw >= Q_EXT) begin
            res = raw[W-1:0] - Q_W;
        end
    end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage modular add/sub pipeline with valid/ready handshake.
// Stage 1 holds the raw W+1-bit sum/difference, stage 2 the corrected
// result. in_ready is combinational from out_ready so a full pipe can
// still take a beat every cycle while draining.
// Optional feature macro: MOD_ADDSUB_RANGE_CHK_EN (out_err range flag).
module mod_addsub_pipe
    import modarith_pkg::*;
#(
    parameter int          W     = 16,
    parameter int unsigned Q     = KYBER_Q,
    parameter int          TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_res,
    output logic [TAG_W-1:0] out_tag
`ifdef MOD_ADDSUB_RANGE_CHK_EN
    ,
    output logic             out_err
`endif
);

    // vld_pipe[1] = stage 1 occupied, vld_pipe[2] = stage 2 occupied
    logic [STAGES:1]   vld_pipe;

    logic [W:0]        s1_raw;
    logic [TAG_W-1:0]  s1_tag;
    s1_ctl_t           s1_ctl;
    s1_ctl_t           s1_ctl_d;

    logic [W-1:0]      s2_res;
    logic [TAG_W-1:0]  s2_tag;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
    logic              s2_err;
`endif

    logic [W-1:0]      corr_res;
    logic [W:0]        raw_d;
    logic              s2_open;
    logic              s1_fire;
    logic              in_fire;

    // stage 2 can take a beat when empty or when its beat leaves this cycle
    assign s2_open  = !vld_pipe[2] || out_ready;
    assign s1_fire  = vld_pipe[1] && s2_open;
    assign in_ready = !vld_pipe[1] || s2_open;
    assign in_fire  = in_valid && in_ready;

    // raw W+1-bit result; sub wraps in two's complement, bit W flags negative
    always_comb begin
        s1_ctl_d    = '0;
        s1_ctl_d.op = in_op;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
        s1_ctl_d.err = ({1'b0, in_a} >= (W+1)'(Q)) || ({1'b0, in_b} >= (W+1)'(Q));
`endif
        if (in_op == OP_SUB)
            raw_d = {1'b0, in_a} - {1'b0, in_b};
        else
            raw_d = {1'b0, in_a} + {1'b0, in_b};
    end

    mod_addsub_corr #(
        .W (W),
        .Q (Q)
    ) u_corr (
        .raw (s1_raw),
        .op  (s1_ctl.op),
        .res (corr_res)
    );

    // valid bits: stage 1 refills on accept, stage 2 follows stage 1 when open
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            if (in_fire)
                vld_pipe[1] <= 1'b1;
            else if (s1_fire)
                vld_pipe[1] <= 1'b0;
            if (s2_open)
                vld_pipe[2] <= vld_pipe[1];
        end
    end

    // stage 1 data: loaded only on an accepted input beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_raw <= '0;
            s1_tag <= '0;
            s1_ctl <= '0;
        end else if (in_fire) begin
            s1_raw <= raw_d;
            s1_tag <= in_tag;
            s1_ctl <= s1_ctl_d;
        end
    end

    // stage 2 data: held while stalled, loaded when stage 1 advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_res <= '0;
            s2_tag <= '0;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
            s2_err <= 1'b0;
`endif
        end else if (s1_fire) begin
            s2_res <= corr_res;
            s2_tag <= s1_tag;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
            s2_err <= s1_ctl.err;
`endif
        end
    end

    assign out_valid = vld_pipe[2];
    assign out_res   = s2_res;
    assign out_tag   = s2_tag;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
    assign out_err   = s2_err;
`endif

endmodule
